fft_out_reader: RTL and testbench

- Unloads a finished transform from the FFT core's result banks after the core signals completion.
- Generates the core's four external bank read addresses and captures the returned real-part words.
- Emits the results as one serial 17-bit stream under a valid/ready handshake, in natural or bit-reversed point order.
- Sits between fft_top (its oRDY, iADDR_RD_0..3 and oDATA_RE_0..3 ports) and the downstream sample consumer.

---
 rtl/fft_out_pkg.sv | 26 ++
 rtl/fft_out_fifo.sv | 61 ++++++
 rtl/fft_out_reader.sv | 165 ++++++++++++++++
 tb/tb_fft_out_reader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_out_pkg.sv
// Shared widths, FSM encoding and index helpers for the FFT result unloader.
package fft_out_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 17;
    localparam int unsigned BANK_W = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Reverses the low n_log2 bits of n; bits above n_log2 come back zero.
    function automatic logic [15:0] bitrev(input logic [15:0] n, input int unsigned n_log2);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(n_log2)) begin
                r[i] = n[int'(n_log2) - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Synchronous skid FIFO; a write and a read in the same clock are both honoured.
module fft_out_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 18,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             rd_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_wr, do_rd;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_rd = rd_i & ~empty_o;
    assign do_wr = wr_i & (~full_o | do_rd);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fft_out_reader.sv
// Unloads the FFT result banks after completion and streams the words out
// under valid/ready, in natural or bit-reversed point order.
module fft_out_reader
    import fft_out_pkg::*;
#(
    parameter int unsigned N_LOG2     = 11,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned ORDER      = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iFFT_RDY,
    output logic [ADDR_W-1:0] oADDR_RD_0,
    output logic [ADDR_W-1:0] oADDR_RD_1,
    output logic [ADDR_W-1:0] oADDR_RD_2,
    output logic [ADDR_W-1:0] oADDR_RD_3,
    input  logic [DATA_W-1:0] iDATA_RE_0,
    input  logic [DATA_W-1:0] iDATA_RE_1,
    input  logic [DATA_W-1:0] iDATA_RE_2,
    input  logic [DATA_W-1:0] iDATA_RE_3,
    output logic [DATA_W-1:0] oDATA,
    output logic              oVALID,
    input  logic              iREADY,
    output logic              oLAST,
    output logic              oBUSY,
    output logic              oDONE
);

    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned Stages = RD_LAT + 1;

    state_e             state_q, state_d;
    logic               rdy_q;
    logic [N_LOG2-1:0]  n_q, n_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [Stages-1:0]  vld_q;
    logic [Stages-1:0]  last_q;
    logic [BANK_W-1:0]  bank_q [Stages];
    logic               done_q, done_d;

    logic               trig, issue, pop, n_last;
    logic [15:0]        k_rev;
    logic [N_LOG2-1:0]  k;
    logic [DATA_W-1:0]  cap_data;
    logic               fifo_full, fifo_empty;
    logic [CntW-1:0]    fifo_count;
    logic [DATA_W:0]    fifo_rdata;
    int unsigned        inflight;
    logic               unused_sig;

    assign trig   = iFFT_RDY & ~rdy_q;
    assign pop    = oVALID & iREADY;
    assign n_last = (n_q == {N_LOG2{1'b1}});
    assign k_rev  = bitrev(16'(n_q), N_LOG2);
    assign k      = (ORDER == 1) ? k_rev[N_LOG2-1:0] : n_q;

    assign unused_sig = fifo_full ^ (^k_rev[15:N_LOG2]);

    // Every issued read still in the return pipe holds a FIFO slot.
    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < Stages; i++) begin
            inflight = inflight + 32'(vld_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    issue   = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                // A word leaving the FIFO this clock frees its slot for a new read.
                if (inflight + 32'(fifo_count) < FIFO_DEPTH + 32'(pop)) begin
                    issue = 1'b1;
                    if (n_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (fifo_empty && (vld_q == '0)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (issue) begin
            addr_d = k[ADDR_W+1:2];
            n_d    = n_q + 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= StIdle;
            rdy_q   <= 1'b0;
            n_q     <= '0;
            addr_q  <= '0;
            vld_q   <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(Stages); i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rdy_q     <= iFFT_RDY;
            n_q       <= n_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            vld_q     <= {vld_q[Stages-2:0], issue};
            last_q    <= {last_q[Stages-2:0], issue & n_last};
            bank_q[0] <= k[BANK_W-1:0];
            for (int i = 1; i < int'(Stages); i++) begin
                bank_q[i] <= bank_q[i-1];
            end
        end
    end

    always_comb begin
        case (bank_q[RD_LAT])
            2'd0:    cap_data = iDATA_RE_0;
            2'd1:    cap_data = iDATA_RE_1;
            2'd2:    cap_data = iDATA_RE_2;
            default: cap_data = iDATA_RE_3;
        endcase
    end

    fft_out_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (DATA_W + 1)
    ) u_fifo (
        .clk_i   (iCLK),
        .rst_ni  (iRESET),
        .wr_i    (vld_q[RD_LAT]),
        .wdata_i ({last_q[RD_LAT], cap_data}),
        .rd_i    (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign oADDR_RD_0 = addr_q;
    assign oADDR_RD_1 = addr_q;
    assign oADDR_RD_2 = addr_q;
    assign oADDR_RD_3 = addr_q;
    assign oVALID     = ~fifo_empty;
    assign oDATA      = oVALID ? fifo_rdata[DATA_W-1:0] : '0;
    assign oLAST      = oVALID & fifo_rdata[DATA_W];
    assign oBUSY      = (state_q != StIdle);
    assign oDONE      = done_q;

endmodule

// File: tb/tb_fft_out_reader.sv
// Bench for fft_out_reader: natural and bit-reversed instances side by side,
// each fed by a bank model whose word at point k is k.
module tb_fft_out_reader;

    localparam int NPTS = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fft_rdy = 1'b0;
    logic ready = 1'b1;
    int   ready_mode = 1;

    always #5 clk = ~clk;

    logic [8:0]  addr0 [4], addr1 [4];
    logic [8:0]  p0a [4], p0b [4], p1a [4], p1b [4];
    logic [16:0] rd0 [4], rd1 [4];
    logic [16:0] dat [2];
    logic        vld [2], lst [2], bsy [2], dne [2];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            p0a[b] <= addr0[b];
            p0b[b] <= p0a[b];
            p1a[b] <= addr1[b];
            p1b[b] <= p1a[b];
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            rd0[b] = {6'd0, p0b[b], 2'(b)};
            rd1[b] = {6'd0, p1b[b], 2'(b)};
        end
    end

    fft_out_reader #(.N_LOG2(11), .RD_LAT(2), .ORDER(0), .FIFO_DEPTH(4)) dut0 (
        .iCLK(clk), .iRESET(rst_n), .iFFT_RDY(fft_rdy),
        .oADDR_RD_0(addr0[0]), .oADDR_RD_1(addr0[1]),
        .oADDR_RD_2(addr0[2]), .oADDR_RD_3(addr0[3]),
        .iDATA_RE_0(rd0[0]), .iDATA_RE_1(rd0[1]), .iDATA_RE_2(rd0[2]), .iDATA_RE_3(rd0[3]),
        .oDATA(dat[0]), .oVALID(vld[0]), .iREADY(ready), .oLAST(lst[0]),
        .oBUSY(bsy[0]), .oDONE(dne[0])
    );

    fft_out_reader #(.N_LOG2(11), .RD_LAT(2), .ORDER(1), .FIFO_DEPTH(4)) dut1 (
        .iCLK(clk), .iRESET(rst_n), .iFFT_RDY(fft_rdy),
        .oADDR_RD_0(addr1[0]), .oADDR_RD_1(addr1[1]),
        .oADDR_RD_2(addr1[2]), .oADDR_RD_3(addr1[3]),
        .iDATA_RE_0(rd1[0]), .iDATA_RE_1(rd1[1]), .iDATA_RE_2(rd1[2]), .iDATA_RE_3(rd1[3]),
        .oDATA(dat[1]), .oVALID(vld[1]), .iREADY(ready), .oLAST(lst[1]),
        .oBUSY(bsy[1]), .oDONE(dne[1])
    );

    typedef struct {
        int n;
        int exp_nat;
        int exp_rev;
    } vec_t;

    vec_t        tbl [9];
    logic [16:0] cap [2][NPTS];
    int          idx [2], last_cnt [2], last_at [2], done_cnt [2];
    logic        hold_v [2];
    logic [16:0] hold_d [2];
    int          checks = 0;
    int          failures = 0;
    int          max_cnt = 0;
    int          stall_seen = 0;

    function automatic int rev11(input int x);
        int r = 0;
        for (int i = 0; i < 11; i++) begin
            r = (r << 1) | (x & 1);
            x = x >> 1;
        end
        return r;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic sample();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                hold_v[d] = 1'b0;
            end else begin
                if (hold_v[d]) begin
                    stall_seen++;
                    checks++;
                    if (!vld[d] || dat[d] != hold_d[d]) begin
                        failures++;
                        $display("FAIL stall_hold dut%0d: valid=%0b data=%0d, expected valid=1 data=%0d",
                                 d, vld[d], dat[d], hold_d[d]);
                    end
                end
                if (vld[d] && ready) begin
                    if (idx[d] < NPTS) cap[d][idx[d]] = dat[d];
                    if (lst[d]) begin
                        last_cnt[d]++;
                        last_at[d] = idx[d];
                    end
                    idx[d]++;
                end
                hold_v[d] = vld[d] && !ready;
                hold_d[d] = dat[d];
                if (dne[d]) done_cnt[d]++;
            end
        end
        if (int'(dut0.u_fifo.count_o) > max_cnt) max_cnt = int'(dut0.u_fifo.count_o);
        if (dut0.u_fifo.wr_i && dut0.u_fifo.full_o && !dut0.u_fifo.rd_i) begin
            $display("FAIL fifo_overflow: write while full, count=%0d", dut0.u_fifo.count_o);
            $fatal(1, "fifo write when full");
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = ($urandom_range(0, 9) < 3);
        endcase
    endtask

    task automatic clear();
        for (int d = 0; d < 2; d++) begin
            idx[d] = 0;
            last_cnt[d] = 0;
            last_at[d] = -1;
            done_cnt[d] = 0;
            hold_v[d] = 1'b0;
            for (int i = 0; i < NPTS; i++) cap[d][i] = '1;
        end
        max_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("done_timeout", 0, 1);
        repeat (5) tick();
    endtask

    task automatic check_unload(input string tag);
        int bad0 = 0;
        int bad1 = 0;
        for (int i = 0; i < NPTS; i++) begin
            if (int'(cap[0][i]) != i) bad0++;
            if (int'(cap[1][i]) != rev11(i)) bad1++;
        end
        check({tag, "_count_nat"}, idx[0], NPTS);
        check({tag, "_count_rev"}, idx[1], NPTS);
        check({tag, "_bad_words_nat"}, bad0, 0);
        check({tag, "_bad_words_rev"}, bad1, 0);
        check({tag, "_last_cnt"}, last_cnt[0] + last_cnt[1], 2);
        check({tag, "_last_at_nat"}, last_at[0], NPTS - 1);
        check({tag, "_last_at_rev"}, last_at[1], NPTS - 1);
        check({tag, "_done_pulses"}, done_cnt[0] + done_cnt[1], 2);
        check({tag, "_fifo_max_le4"}, int'(max_cnt <= 4), 1);
    endtask

    initial begin
        int n;
        int flag;
        tbl[0] = '{0, 0, 0};
        tbl[1] = '{1, 1, 1024};
        tbl[2] = '{2, 2, 512};
        tbl[3] = '{3, 3, 1536};
        tbl[4] = '{4, 4, 256};
        tbl[5] = '{5, 5, 1280};
        tbl[6] = '{100, 100, 304};
        tbl[7] = '{1024, 1024, 1};
        tbl[8] = '{2047, 2047, 2047};
        clear();

        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_valid%0d", d), int'(vld[d]), 0);
            check($sformatf("rst_data%0d", d), int'(dat[d]), 0);
            check($sformatf("rst_last%0d", d), int'(lst[d]), 0);
            check($sformatf("rst_busy%0d", d), int'(bsy[d]), 0);
            check($sformatf("rst_done%0d", d), int'(dne[d]), 0);
        end
        check("rst_addr", int'(addr0[0] | addr0[1] | addr0[2] | addr0[3] | addr1[0] | addr1[3]), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Natural and reversed unload at full rate, first-valid latency.
        clear();
        fft_rdy = 1'b1;
        tick();
        check("busy_on_trigger", int'(bsy[0] & bsy[1]), 1);
        check("valid_t0", int'(vld[0]), 0);
        tick();
        tick();
        check("valid_t2", int'(vld[0] | vld[1]), 0);
        tick();
        check("valid_t3", int'(vld[0] & vld[1]), 1);
        check("first_word_nat", int'(dat[0]), 0);
        check("first_word_rev", int'(dat[1]), 0);
        wait_done(2300);
        check_unload("full_rate");
        for (int i = 0; i < 9; i++) begin
            check($sformatf("tbl_nat_n%0d", tbl[i].n), int'(cap[0][tbl[i].n]), tbl[i].exp_nat);
            check($sformatf("tbl_rev_n%0d", tbl[i].n), int'(cap[1][tbl[i].n]), tbl[i].exp_rev);
        end

        // Level held high must not retrigger.
        flag = 0;
        repeat (2700) begin
            tick();
            if (bsy[0] || bsy[1]) flag = 1;
        end
        check("no_retrigger_level", flag, 0);

        // Random backpressure, with a second edge mid-unload that must be ignored.
        fft_rdy = 1'b0;
        tick();
        clear();
        stall_seen = 0;
        ready_mode = 2;
        fft_rdy = 1'b1;
        n = 0;
        while (idx[0] < 500 && n < 5000) begin
            tick();
            n++;
        end
        fft_rdy = 1'b0;
        tick();
        tick();
        fft_rdy = 1'b1;
        wait_done(12000);
        check_unload("random_ready");
        check("stalls_exercised", int'(stall_seen > 0), 1);
        ready_mode = 1;
        flag = 0;
        repeat (50) begin
            tick();
            if (bsy[0] || bsy[1]) flag = 1;
        end
        check("no_retrigger_mid_edge", flag, 0);

        // Reset at word 700 aborts; a fresh edge restarts from n=0.
        fft_rdy = 1'b0;
        tick();
        clear();
        fft_rdy = 1'b1;
        n = 0;
        while (idx[0] < 700 && n < 1000) begin
            tick();
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", int'(vld[0] | vld[1]), 0);
        check("abort_data", int'(dat[0] | dat[1]), 0);
        check("abort_busy", int'(bsy[0] | bsy[1]), 0);
        check("abort_last_done", int'(lst[0] | lst[1] | dne[0] | dne[1]), 0);
        check("abort_addr", int'(addr0[0] | addr1[0]), 0);
        fft_rdy = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        clear();
        fft_rdy = 1'b1;
        wait_done(2300);
        check_unload("after_reset");

        // Backpressure from the trigger: exactly four reads, then resume in order.
        fft_rdy = 1'b0;
        ready_mode = 0;
        ready = 1'b0;
        tick();
        clear();
        fft_rdy = 1'b1;
        repeat (10) tick();
        check("stall_fifo_full", int'(dut0.u_fifo.count_o), 4);
        check("stall_valid", int'(vld[0] & vld[1]), 1);
        check("stall_addr_nat", int'(addr0[2]), 0);
        check("stall_addr_rev", int'(addr1[1]), 384);
        check("stall_head_rev", int'(dat[1]), 0);
        check("stall_no_xfer", idx[0] + idx[1], 0);
        ready_mode = 1;
        wait_done(2300);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("resume_word%0d", i), int'(cap[0][i]), i);
        end
        check_unload("stall_start");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
